// File: rtl/exforwardamux.sv
// EX-stage operand A forwarding select.
package exforwardamux;
  typedef enum logic [1:0] {
    no_forward      = 2'b00,
    mem_alu_out     = 2'b01,
    regfile_MUX_out = 2'b10
  } exforwardamux_sel_t;
endpackage

// File: rtl/exforwardbmux.sv
// EX-stage operand B forwarding select.
package exforwardbmux;
  typedef enum logic [1:0] {
    no_forward      = 2'b00,
    mem_alu_out     = 2'b01,
    regfile_MUX_out = 2'b10
  } exforwardbmux_sel_t;
endpackage

// File: rtl/hazard_pkg.sv
// Pipeline control state encoding and register-match helper.
package hazard_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    MEM_WAIT = 2'd2
  } hazard_state_t;

  // x0 is hardwired, so it never produces a dependency.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction
endpackage

// File: rtl/idforwardamux.sv
// ID-stage operand A forwarding select (branch compare inputs).
package idforwardamux;
  typedef enum logic [1:0] {
    no_forward   = 2'b00,
    ex_br_en     = 2'b01,
    mem_pc_plus4 = 2'b10,
    mem_alu_out  = 2'b11
  } idforwardamux_sel_t;
endpackage

// File: rtl/idforwardbmux.sv
// ID-stage operand B forwarding select (branch compare inputs).
package idforwardbmux;
  typedef enum logic [1:0] {
    no_forward   = 2'b00,
    ex_br_en     = 2'b01,
    mem_pc_plus4 = 2'b10,
    mem_alu_out  = 2'b11
  } idforwardbmux_sel_t;
endpackage

// File: rtl/irmux.sv
// Instruction-register mux select: fetched word or a nop.
package irmux;
  typedef enum logic {
    imem_rdata = 1'b0,
    nop        = 1'b1
  } irmux_sel_t;
endpackage

// File: rtl/pcmux.sv
// PC mux select encoding shared by the datapath and pipeline control.
package pcmux;
  typedef enum logic [1:0] {
    pc_plus4  = 2'b00,
    adder_out = 2'b01,
    alu_mod2  = 2'b10
  } pcmux_sel_t;
endpackage

// File: rtl/regfilemux.sv
// Register-file write-back mux select encoding.
package regfilemux;
  typedef enum logic [2:0] {
    alu_out  = 3'd0,
    br_en    = 3'd1,
    u_imm    = 3'd2,
    lw       = 3'd3,
    pc_plus4 = 3'd4,
    lb       = 3'd5,
    lbu      = 3'd6,
    lh       = 3'd7
  } regfilemux_sel_t;
endpackage

// File: rtl/wbmemforwardmux.sv
// Store-data forwarding select for the MEM stage.
package wbmemforwardmux;
  typedef enum logic {
    no_forward      = 1'b0,
    regfile_MUX_out = 1'b1
  } wbmemforwardmux_sel_t;
endpackage

// File: rtl/fwd_operand_sel.sv
// Forwarding select for one operand; ID_STAGE picks the ID-stage rule set
// (branch operands) instead of the EX-stage rule set (ALU operands).
module fwd_operand_sel
  import hazard_pkg::*;
#(
  parameter bit ID_STAGE = 1'b0
) (
  input  logic [4:0]                  rs_i,
  input  logic [4:0]                  ex_rd_i,
  input  logic [4:0]                  mem_rd_i,
  input  logic [4:0]                  wb_rd_i,
  input  logic                        ex_regwrite_i,
  input  logic                        mem_regwrite_i,
  input  logic                        wb_regwrite_i,
  input  regfilemux::regfilemux_sel_t ex_regfilemux_sel_i,
  input  regfilemux::regfilemux_sel_t mem_regfilemux_sel_i,
  output logic [1:0]                  sel_o
);

  logic ex_hit, mem_hit, wb_hit;

  assign ex_hit  = ex_regwrite_i  && reg_hit(rs_i, ex_rd_i);
  assign mem_hit = mem_regwrite_i && reg_hit(rs_i, mem_rd_i);
  assign wb_hit  = wb_regwrite_i  && reg_hit(rs_i, wb_rd_i);

  always_comb begin
    sel_o = '0;
    if (ID_STAGE) begin
      if (ex_hit && ex_regfilemux_sel_i == regfilemux::br_en)
        sel_o = idforwardamux::ex_br_en;
      else if (mem_hit && mem_regfilemux_sel_i == regfilemux::pc_plus4)
        sel_o = idforwardamux::mem_pc_plus4;
      else if (mem_hit && mem_regfilemux_sel_i == regfilemux::alu_out)
        sel_o = idforwardamux::mem_alu_out;
    end else begin
      if (mem_hit && mem_regfilemux_sel_i == regfilemux::alu_out)
        sel_o = exforwardamux::mem_alu_out;
      else if (wb_hit)
        sel_o = exforwardamux::regfile_MUX_out;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding selects, nop insertion and pipeline-register enables for the
// five-stage core. Optional perf counters under `HAZARD_PERF_EN`.
module hazard_forward_unit
  import hazard_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic [4:0]                          id_rs1,
  input  logic [4:0]                          id_rs2,
  input  logic [4:0]                          ex_rs1,
  input  logic [4:0]                          ex_rs2,
  input  logic [4:0]                          ex_rd,
  input  logic [4:0]                          mem_rs2,
  input  logic [4:0]                          mem_rd,
  input  logic [4:0]                          wb_rd,
  input  logic                                ex_regwrite,
  input  logic                                mem_regwrite,
  input  logic                                wb_regwrite,
  input  logic                                ex_is_load,
  input  logic                                mem_is_store,
  input  regfilemux::regfilemux_sel_t         ex_regfilemux_sel,
  input  regfilemux::regfilemux_sel_t         mem_regfilemux_sel,
  input  pcmux::pcmux_sel_t                   ex_pcmux_sel,
  input  logic                                imem_read,
  input  logic                                imem_resp,
  input  logic                                dmem_access,
  input  logic                                dmem_resp,
  output logic                                pc_load,
  output logic                                if_id_load,
  output logic                                id_ex_load,
  output logic                                ex_mem_load,
  output logic                                mem_wb_load,
  output logic                                id_ex_bubble,
  output irmux::irmux_sel_t                   irmux_sel,
  output idforwardamux::idforwardamux_sel_t   idforwarda_sel,
  output idforwardbmux::idforwardbmux_sel_t   idforwardb_sel,
  output exforwardamux::exforwardamux_sel_t   exforwarda_sel,
  output exforwardbmux::exforwardbmux_sel_t   exforwardb_sel,
  output wbmemforwardmux::wbmemforwardmux_sel_t wbmemforward_sel,
  output logic                                stall
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                         perf_stall_cycles,
  output logic [31:0]                         perf_flush_count
`endif
);

  hazard_state_t state_q, state_d;
  logic          flush_pending_q, flush_pending_d;
  logic          mem_wait, load_use, redirect, flush;
  logic [4:0]    loads;
  logic [1:0]    exa_raw, exb_raw, ida_raw, idb_raw;

  fwd_operand_sel #(.ID_STAGE(1'b0)) u_exa (
    .rs_i(ex_rs1), .ex_rd_i(ex_rd), .mem_rd_i(mem_rd), .wb_rd_i(wb_rd),
    .ex_regwrite_i(ex_regwrite), .mem_regwrite_i(mem_regwrite), .wb_regwrite_i(wb_regwrite),
    .ex_regfilemux_sel_i(ex_regfilemux_sel), .mem_regfilemux_sel_i(mem_regfilemux_sel),
    .sel_o(exa_raw)
  );

  fwd_operand_sel #(.ID_STAGE(1'b0)) u_exb (
    .rs_i(ex_rs2), .ex_rd_i(ex_rd), .mem_rd_i(mem_rd), .wb_rd_i(wb_rd),
    .ex_regwrite_i(ex_regwrite), .mem_regwrite_i(mem_regwrite), .wb_regwrite_i(wb_regwrite),
    .ex_regfilemux_sel_i(ex_regfilemux_sel), .mem_regfilemux_sel_i(mem_regfilemux_sel),
    .sel_o(exb_raw)
  );

  fwd_operand_sel #(.ID_STAGE(1'b1)) u_ida (
    .rs_i(id_rs1), .ex_rd_i(ex_rd), .mem_rd_i(mem_rd), .wb_rd_i(wb_rd),
    .ex_regwrite_i(ex_regwrite), .mem_regwrite_i(mem_regwrite), .wb_regwrite_i(wb_regwrite),
    .ex_regfilemux_sel_i(ex_regfilemux_sel), .mem_regfilemux_sel_i(mem_regfilemux_sel),
    .sel_o(ida_raw)
  );

  fwd_operand_sel #(.ID_STAGE(1'b1)) u_idb (
    .rs_i(id_rs2), .ex_rd_i(ex_rd), .mem_rd_i(mem_rd), .wb_rd_i(wb_rd),
    .ex_regwrite_i(ex_regwrite), .mem_regwrite_i(mem_regwrite), .wb_regwrite_i(wb_regwrite),
    .ex_regfilemux_sel_i(ex_regfilemux_sel), .mem_regfilemux_sel_i(mem_regfilemux_sel),
    .sel_o(idb_raw)
  );

  assign exforwarda_sel = rst ? exforwardamux::no_forward
                              : exforwardamux::exforwardamux_sel_t'(exa_raw);
  assign exforwardb_sel = rst ? exforwardbmux::no_forward
                              : exforwardbmux::exforwardbmux_sel_t'(exb_raw);
  assign idforwarda_sel = rst ? idforwardamux::no_forward
                              : idforwardamux::idforwardamux_sel_t'(ida_raw);
  assign idforwardb_sel = rst ? idforwardbmux::no_forward
                              : idforwardbmux::idforwardbmux_sel_t'(idb_raw);
  assign wbmemforward_sel = (!rst && mem_is_store && wb_regwrite && reg_hit(mem_rs2, wb_rd))
                            ? wbmemforwardmux::regfile_MUX_out
                            : wbmemforwardmux::no_forward;

  assign mem_wait = (imem_read && !imem_resp) || (dmem_access && !dmem_resp);
  assign load_use = ex_is_load && (reg_hit(id_rs1, ex_rd) || reg_hit(id_rs2, ex_rd));
  assign redirect = ex_pcmux_sel != pcmux::pc_plus4;
  // A redirect held back by a memory stall is replayed on the first advancing cycle.
  assign flush    = !mem_wait && (redirect || flush_pending_q);

  always_comb begin
    state_d         = state_q;
    flush_pending_d = flush_pending_q;
    loads           = '1;
    id_ex_bubble    = 1'b0;
    irmux_sel       = irmux::imem_rdata;
    stall           = 1'b0;
    if (rst) begin
      loads           = '0;
      id_ex_bubble    = 1'b1;
      irmux_sel       = irmux::nop;
      state_d         = RUN;
      flush_pending_d = 1'b0;
    end else if (mem_wait) begin
      loads           = '0;
      stall           = 1'b1;
      state_d         = MEM_WAIT;
      flush_pending_d = flush_pending_q || redirect;
    end else if (flush) begin
      id_ex_bubble    = 1'b1;
      irmux_sel       = irmux::nop;
      state_d         = RUN;
      flush_pending_d = 1'b0;
    end else if (load_use && state_q != LOAD_USE) begin
      loads[4:3]      = 2'b00;
      id_ex_bubble    = 1'b1;
      stall           = 1'b1;
      state_d         = LOAD_USE;
    end else begin
      state_d         = RUN;
    end
  end

  assign {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = loads;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush) perf_flush_count  <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed scenarios then random traffic.
module tb_hazard_forward_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rs2, mem_rd, wb_rd;
  logic ex_regwrite, mem_regwrite, wb_regwrite, ex_is_load, mem_is_store;
  regfilemux::regfilemux_sel_t ex_regfilemux_sel, mem_regfilemux_sel;
  pcmux::pcmux_sel_t ex_pcmux_sel;
  logic imem_read, imem_resp, dmem_access, dmem_resp;
  logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load, id_ex_bubble, stall;
  irmux::irmux_sel_t irmux_sel;
  idforwardamux::idforwardamux_sel_t idforwarda_sel;
  idforwardbmux::idforwardbmux_sel_t idforwardb_sel;
  exforwardamux::exforwardamux_sel_t exforwarda_sel;
  exforwardbmux::exforwardbmux_sel_t exforwardb_sel;
  wbmemforwardmux::wbmemforwardmux_sel_t wbmemforward_sel;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  hazard_forward_unit dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .mem_rs2(mem_rs2), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .ex_is_load(ex_is_load), .mem_is_store(mem_is_store),
    .ex_regfilemux_sel(ex_regfilemux_sel), .mem_regfilemux_sel(mem_regfilemux_sel),
    .ex_pcmux_sel(ex_pcmux_sel),
    .imem_read(imem_read), .imem_resp(imem_resp), .dmem_access(dmem_access), .dmem_resp(dmem_resp),
    .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
    .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
    .id_ex_bubble(id_ex_bubble), .irmux_sel(irmux_sel),
    .idforwarda_sel(idforwarda_sel), .idforwardb_sel(idforwardb_sel),
    .exforwarda_sel(exforwarda_sel), .exforwardb_sel(exforwardb_sel),
    .wbmemforward_sel(wbmemforward_sel), .stall(stall)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
`endif
  );

  typedef struct {
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rs2, mem_rd, wb_rd;
    logic       ex_rw, mem_rw, wb_rw, ex_load, mem_store;
    logic [2:0] ex_rf, mem_rf;
    logic [1:0] ex_pc;
    logic       iread, iresp, daccess, dresp;
  } stim_t;

  typedef struct {
    logic [4:0] loads;
    logic       bubble, ir, stall, wbm;
    logic [1:0] exa, exb, ida, idb;
  } exp_t;

  exp_t q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state: "the previous cycle was a load-use stall" and
  // "a redirect was swallowed by a memory stall and is still owed".
  bit          prev_was_lu;
  bit          owed_flush;
  logic [31:0] m_stalls, m_flushes;

  function automatic bit dep(input logic [4:0] src, input logic [4:0] dst);
    return src != 0 && src == dst;
  endfunction

  function automatic logic [1:0] ex_fwd(input stim_t s, input logic [4:0] r);
    if (s.mem_rw && dep(r, s.mem_rd) && s.mem_rf == regfilemux::alu_out) return exforwardamux::mem_alu_out;
    if (s.wb_rw && dep(r, s.wb_rd)) return exforwardamux::regfile_MUX_out;
    return exforwardamux::no_forward;
  endfunction

  function automatic logic [1:0] id_fwd(input stim_t s, input logic [4:0] r);
    if (s.ex_rw && dep(r, s.ex_rd) && s.ex_rf == regfilemux::br_en) return idforwardamux::ex_br_en;
    if (s.mem_rw && dep(r, s.mem_rd) && s.mem_rf == regfilemux::pc_plus4) return idforwardamux::mem_pc_plus4;
    if (s.mem_rw && dep(r, s.mem_rd) && s.mem_rf == regfilemux::alu_out) return idforwardamux::mem_alu_out;
    return idforwardamux::no_forward;
  endfunction

  task automatic model(input stim_t s, output exp_t e);
    bit waiting, redirect, hazard;
    e.loads = 5'b11111; e.bubble = 1'b0; e.ir = irmux::imem_rdata; e.stall = 1'b0;
    if (s.rst) begin
      e.loads = 5'b00000; e.bubble = 1'b1; e.ir = irmux::nop;
      e.exa = 2'd0; e.exb = 2'd0; e.ida = 2'd0; e.idb = 2'd0; e.wbm = 1'b0;
      prev_was_lu = 0; owed_flush = 0; m_stalls = 0; m_flushes = 0;
      return;
    end
    e.exa = ex_fwd(s, s.ex_rs1);
    e.exb = ex_fwd(s, s.ex_rs2);
    e.ida = id_fwd(s, s.id_rs1);
    e.idb = id_fwd(s, s.id_rs2);
    e.wbm = s.mem_store && s.wb_rw && dep(s.mem_rs2, s.wb_rd);
    waiting  = (s.iread && !s.iresp) || (s.daccess && !s.dresp);
    redirect = s.ex_pc != pcmux::pc_plus4;
    hazard   = s.ex_load && (dep(s.id_rs1, s.ex_rd) || dep(s.id_rs2, s.ex_rd));
    if (waiting) begin
      e.loads = 5'b00000; e.stall = 1'b1;
      owed_flush = owed_flush || redirect;
      prev_was_lu = 0;
    end else if (redirect || owed_flush) begin
      e.bubble = 1'b1; e.ir = irmux::nop;
      owed_flush = 0; prev_was_lu = 0;
      m_flushes++;
    end else if (hazard && !prev_was_lu) begin
      e.loads = 5'b00111; e.bubble = 1'b1; e.stall = 1'b1;
      prev_was_lu = 1;
    end else begin
      prev_was_lu = 0;
    end
    if (e.stall) m_stalls++;
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk); #1;
    rst = s.rst;
    id_rs1 = s.id_rs1; id_rs2 = s.id_rs2; ex_rs1 = s.ex_rs1; ex_rs2 = s.ex_rs2; ex_rd = s.ex_rd;
    mem_rs2 = s.mem_rs2; mem_rd = s.mem_rd; wb_rd = s.wb_rd;
    ex_regwrite = s.ex_rw; mem_regwrite = s.mem_rw; wb_regwrite = s.wb_rw;
    ex_is_load = s.ex_load; mem_is_store = s.mem_store;
    ex_regfilemux_sel  = regfilemux::regfilemux_sel_t'(s.ex_rf);
    mem_regfilemux_sel = regfilemux::regfilemux_sel_t'(s.mem_rf);
    ex_pcmux_sel = pcmux::pcmux_sel_t'(s.ex_pc);
    imem_read = s.iread; imem_resp = s.iresp; dmem_access = s.daccess; dmem_resp = s.dresp;
    model(s, e);
    q.push_back(e);
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s = '{default: '0};
    s.iread = 1'b1; s.iresp = 1'b1;
    s.ex_rf = regfilemux::alu_out; s.mem_rf = regfilemux::alu_out;
    s.ex_pc = pcmux::pc_plus4;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("loads", 32'({pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load}), 32'(e.loads));
        check("id_ex_bubble", 32'(id_ex_bubble), 32'(e.bubble));
        check("irmux_sel", 32'(irmux_sel), 32'(e.ir));
        check("stall", 32'(stall), 32'(e.stall));
        check("exforwarda_sel", 32'(exforwarda_sel), 32'(e.exa));
        check("exforwardb_sel", 32'(exforwardb_sel), 32'(e.exb));
        check("idforwarda_sel", 32'(idforwarda_sel), 32'(e.ida));
        check("idforwardb_sel", 32'(idforwardb_sel), 32'(e.idb));
        check("wbmemforward_sel", 32'(wbmemforward_sel), 32'(e.wbm));
      end
    end
  end

  initial begin : driver
    stim_t s;
    s = quiet(); s.rst = 1'b1;
    apply(s); apply(s);

    // EX forwarding from MEM alu_out, then with x0
    s = quiet(); s.mem_rw = 1; s.mem_rd = 5; s.ex_rs1 = 5; apply(s);
    s.mem_rd = 0; s.ex_rs1 = 0; apply(s);

    // load-use: lw x3 in EX, add x4,x3,x1 in ID
    s = quiet(); s.ex_load = 1; s.ex_rw = 1; s.ex_rd = 3; s.ex_rf = regfilemux::lw;
    s.id_rs1 = 3; s.id_rs2 = 1; apply(s);
    apply(s);                                  // hazard still visible in LOAD_USE: no second stall
    s = quiet(); s.mem_rw = 1; s.mem_rd = 3; s.mem_rf = regfilemux::lw; s.id_rs1 = 3; apply(s);
    s = quiet(); s.wb_rw = 1; s.wb_rd = 3; s.ex_rs1 = 3; apply(s);

    // imem_resp low for 3 cycles
    s = quiet(); s.iresp = 0;
    repeat (3) apply(s);
    s.iresp = 1; apply(s);

    // redirect during a 2-cycle dmem wait, held through release
    s = quiet(); s.daccess = 1; s.dresp = 0; s.ex_pc = pcmux::adder_out;
    repeat (2) apply(s);
    s.dresp = 1; apply(s);
    s = quiet(); apply(s);

    // redirect seen only while stalled is still applied on release
    s = quiet(); s.daccess = 1; s.dresp = 0; s.ex_pc = pcmux::alu_mod2; apply(s);
    s.ex_pc = pcmux::pc_plus4; apply(s);
    s.dresp = 1; apply(s);
    s = quiet(); apply(s);

    // store-data forwarding
    s = quiet(); s.mem_store = 1; s.mem_rs2 = 7; s.wb_rw = 1; s.wb_rd = 7; apply(s);
    s.mem_rs2 = 0; s.wb_rd = 0; apply(s);

    // reset during MEM_WAIT with a pending redirect
    s = quiet(); s.iresp = 0; s.ex_pc = pcmux::adder_out; apply(s); apply(s);
    s = quiet(); s.rst = 1; apply(s);
    s = quiet(); apply(s);
    s.ex_load = 1; s.ex_rd = 9; s.id_rs2 = 9; apply(s);

    // redirect beats load-use in the same cycle
    s = quiet(); s.ex_load = 1; s.ex_rd = 4; s.id_rs1 = 4; s.ex_pc = pcmux::adder_out; apply(s);

    // ID forwarding priority: ex br_en over mem alu_out; mem pc_plus4 on operand B
    s = quiet(); s.ex_rw = 1; s.ex_rd = 6; s.ex_rf = regfilemux::br_en; s.id_rs1 = 6;
    s.mem_rw = 1; s.mem_rd = 6; s.id_rs2 = 10; apply(s);
    s.mem_rd = 10; s.mem_rf = regfilemux::pc_plus4; apply(s);

    for (int i = 0; i < 2000; i++) begin
      s.rst       = ($urandom_range(0, 49) == 0);
      s.id_rs1    = 5'($urandom_range(0, 7));
      s.id_rs2    = 5'($urandom_range(0, 7));
      s.ex_rs1    = 5'($urandom_range(0, 7));
      s.ex_rs2    = 5'($urandom_range(0, 7));
      s.ex_rd     = 5'($urandom_range(0, 7));
      s.mem_rs2   = 5'($urandom_range(0, 7));
      s.mem_rd    = 5'($urandom_range(0, 7));
      s.wb_rd     = 5'($urandom_range(0, 7));
      s.ex_rw     = 1'($urandom_range(0, 1));
      s.mem_rw    = 1'($urandom_range(0, 1));
      s.wb_rw     = 1'($urandom_range(0, 1));
      s.ex_load   = ($urandom_range(0, 9) < 3);
      s.mem_store = 1'($urandom_range(0, 1));
      s.ex_rf     = 3'($urandom_range(0, 7));
      s.mem_rf    = 3'($urandom_range(0, 7));
      s.ex_pc     = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      s.iread     = ($urandom_range(0, 9) != 0);
      s.iresp     = ($urandom_range(0, 7) != 0);
      s.daccess   = 1'($urandom_range(0, 1));
      s.dresp     = ($urandom_range(0, 5) != 0);
      apply(s);
    end

    s = quiet(); apply(s); apply(s);

    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

`ifdef HAZARD_PERF_EN
    @(posedge clk); #1;
    check("perf_stall_cycles", perf_stall_cycles, m_stalls);
    check("perf_flush_count", perf_flush_count, m_flushes);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
